arm_hps_system_hex_bank: RTL and testbench
==========================================

ARM_HPS_SYSTEM_HEX_BANK -- requirements
Module: arm_hps_system_hex_bank

Interface
REQ-001 Parameter NUM_CH, default 6, number of output channels (1..8).
REQ-002 Parameter CH_W, default 8, bits per channel (1..32).
REQ-003 Parameter DIV_W, default 26, blink-period counter width (1..32).
REQ-004 Parameter INV_RST, default 0, reset value of the polarity-invert bit.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset_n  input  1  reset, asynchronous assert and active-low.
REQ-007 address  input  4  Avalon-MM word address.
REQ-008 chipselect  input  1  slave select.
REQ-009 write_n  input  1  active-low write strobe, qualified by chipselect.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  combinational read data, zero wait states.
REQ-012 out_port  output  NUM_CH*CH_W  registered outputs; channel i occupies bits [i*CH_W +: CH_W].

Function
REQ-013 A write SHALL occur on a clk edge with chipselect=1 and write_n=0; a write without chipselect SHALL have no effect.
REQ-014 Addresses 0x0-0x7 SHALL be DATA[i], CH_W bits, writedata[CH_W-1:0]; i >= NUM_CH SHALL read 0 and ignore writes.
REQ-015 0x8 SHALL be BLINK_MASK, NUM_CH bits, one per channel.
REQ-016 0x9 SHALL be BLINK_PERIOD, DIV_W bits, in clk cycles per half-period.
REQ-017 0xA SHALL be CTRL: bit0 EN (0 = blank all), bit1 INV (invert all out_port bits).
REQ-018 0xB SHALL be STATUS, read-only: bit0 PHASE; writes SHALL be ignored.
REQ-019 0xC SHALL be SET: write ORs writedata[NUM_CH-1:0] into BLINK_MASK; reads 0.
REQ-020 0xD SHALL be CLR: write clears BLINK_MASK bits where writedata is 1; reads 0.
REQ-021 Addresses 0xE-0xF SHALL read 0 and ignore writes.
REQ-022 readdata SHALL be zero-extended register contents, combinational on address, independent of chipselect.
REQ-023 Blink counter SHALL increment each cycle while BLINK_PERIOD != 0; on reaching BLINK_PERIOD-1 it SHALL wrap to 0 and toggle PHASE in the same edge.
REQ-024 BLINK_PERIOD == 0 SHALL hold counter and PHASE at 0 (steady display).
REQ-025 A write to BLINK_PERIOD SHALL clear counter and PHASE on the same edge, overriding any wrap that edge.
REQ-026 Channel i pre-invert value SHALL be DATA[i] when EN=1 and not (BLINK_MASK[i]=1 and PHASE=1), else 0.
REQ-027 out_port SHALL be the pre-invert value XOR INV, registered: a write updates out_port on the following edge (latency 1 cycle).
REQ-028 PHASE toggle SHALL reach out_port one edge after the toggle edge.
REQ-029 Writes to SET/CLR SHALL act on BLINK_MASK in one cycle; SET and CLR never coincide (single address).

Reset
REQ-030 reset_n low SHALL asynchronously clear DATA[*], BLINK_MASK, BLINK_PERIOD, counter, PHASE; set EN=1, INV=INV_RST.
REQ-031 out_port SHALL reset to all INV_RST bits (all 0 for default); reset mid-blink SHALL restart counter from 0 after release.

Structure
REQ-032 Shared package arm_hps_system_hex_pkg SHALL hold register address constants (0x0-0xD) and CTRL bit indices.
REQ-033 Blink counter/PHASE SHALL be sub-module arm_hps_system_hex_blink_timer (inputs period, period write strobe; output phase).

Verification
REQ-034 Reset, then write DATA[2]=0x5A -> out_port[23:16]=0x5A one cycle later, other channels 0, readdata at 0x2 = 0x5A.
REQ-035 BLINK_PERIOD=4, SET 0x04 -> channel 2 alternates 0x5A/0x00 every 4 cycles; STATUS bit0 toggles every 4 cycles.
REQ-036 Mid-blink write BLINK_PERIOD=4 with PHASE=1 -> PHASE=0 next cycle, next toggle exactly 4 cycles later.
REQ-037 CTRL=0x2 -> all out_port bits 1 except channel 2 = ~0x5A... corrected: EN=0 blanks, so out_port all 1s; CTRL=0x3 -> channel 2 = 0xA5, others 0xFF.
REQ-038 Write DATA[7]=0xFF and address 0xE with NUM_CH=6 -> no out_port change, reads return 0; write with chipselect=0 -> no change.
REQ-039 Assert reset_n mid-blink -> out_port immediately 0, BLINK_PERIOD reads 0, EN reads 1.

Source files
------------

// File: rtl/arm_hps_system_hex_pkg.sv
// Shared register map and control-bit layout for the hex display bank.
package arm_hps_system_hex_pkg;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] ADDR_DATA0        = 4'h0;
   localparam logic [ADDR_W-1:0] ADDR_DATA7        = 4'h7;
   localparam logic [ADDR_W-1:0] ADDR_BLINK_MASK   = 4'h8;
   localparam logic [ADDR_W-1:0] ADDR_BLINK_PERIOD = 4'h9;
   localparam logic [ADDR_W-1:0] ADDR_CTRL         = 4'hA;
   localparam logic [ADDR_W-1:0] ADDR_STATUS       = 4'hB;
   localparam logic [ADDR_W-1:0] ADDR_SET          = 4'hC;
   localparam logic [ADDR_W-1:0] ADDR_CLR          = 4'hD;

   localparam int unsigned CTRL_EN_BIT      = 0;
   localparam int unsigned CTRL_INV_BIT     = 1;
   localparam int unsigned STATUS_PHASE_BIT = 0;

   // CTRL register image; packed so it reads back directly as {inv, en}
   typedef struct packed {
      logic inv;
      logic en;
   } ctrl_t;

   // DATA[0..7] occupy the lower half of the map
   function automatic logic is_data_addr(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1] == 1'b0;
   endfunction

endpackage

// File: rtl/arm_hps_system_hex_blink_timer.sv
// Half-period counter producing the blink PHASE; a period write restarts it.
module arm_hps_system_hex_blink_timer #(
   parameter int unsigned DIV_W = 26
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [DIV_W-1:0] period,
   input  logic             period_wr,
   output logic             phase
);

   logic [DIV_W-1:0] cnt_q;

   // Period write wins over wrap; a zero period parks the display steady
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         phase <= 1'b0;
      end else if (period_wr || (period == '0)) begin
         cnt_q <= '0;
         phase <= 1'b0;
      end else if (cnt_q == (period - DIV_W'(1))) begin
         cnt_q <= '0;
         phase <= ~phase;
      end else begin
         cnt_q <= cnt_q + DIV_W'(1);
      end
   end

endmodule

// File: rtl/arm_hps_system_hex_bank.sv
// Avalon-MM hex/LED channel bank with per-channel blink, global enable and invert.
module arm_hps_system_hex_bank
   import arm_hps_system_hex_pkg::*;
#(
   parameter int unsigned NUM_CH  = 6,
   parameter int unsigned CH_W    = 8,
   parameter int unsigned DIV_W   = 26,
   parameter bit          INV_RST = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [3:0]             address,
   input  logic                   chipselect,
   input  logic                   write_n,
   input  logic [31:0]            writedata,
   output logic [31:0]            readdata,
   output logic [NUM_CH*CH_W-1:0] out_port
);

   localparam int unsigned OUT_W = NUM_CH * CH_W;

   logic [CH_W-1:0]   data_q [NUM_CH];
   logic [NUM_CH-1:0] mask_q;
   logic [DIV_W-1:0]  period_q;
   ctrl_t             ctrl_q;
   logic              phase;
   logic              wr_c;
   logic              period_wr_c;
   logic [OUT_W-1:0]  out_next;
   logic              unused_wd;

   assign wr_c        = chipselect & ~write_n;
   assign period_wr_c = wr_c && (address == ADDR_BLINK_PERIOD);
   assign unused_wd   = ^writedata;

   // Channel data; slots at or above NUM_CH have no storage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_CH; i++) data_q[i] <= '0;
      end else if (wr_c && is_data_addr(address)) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (address[2:0] == 3'(i)) data_q[i] <= writedata[CH_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mask_q   <= '0;
         period_q <= '0;
         ctrl_q   <= '{inv: INV_RST, en: 1'b1};
      end else if (wr_c) begin
         case (address)
            ADDR_BLINK_MASK:   mask_q   <= writedata[NUM_CH-1:0];
            ADDR_SET:          mask_q   <= mask_q | writedata[NUM_CH-1:0];
            ADDR_CLR:          mask_q   <= mask_q & ~writedata[NUM_CH-1:0];
            ADDR_BLINK_PERIOD: period_q <= writedata[DIV_W-1:0];
            ADDR_CTRL: begin
               ctrl_q.en  <= writedata[CTRL_EN_BIT];
               ctrl_q.inv <= writedata[CTRL_INV_BIT];
            end
            default: ;
         endcase
      end
   end

   arm_hps_system_hex_blink_timer #(.DIV_W(DIV_W)) u_blink_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .period    (period_q),
      .period_wr (period_wr_c),
      .phase     (phase)
   );

   // Blinking channels go dark during the PHASE=1 half-period
   always_comb begin
      out_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ctrl_q.en && !(mask_q[i] && phase)) out_next[i*CH_W +: CH_W] = data_q[i];
      end
      out_next = out_next ^ {OUT_W{ctrl_q.inv}};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) out_port <= {OUT_W{INV_RST}};
      else          out_port <= out_next;
   end

   // Zero-wait read mux, decoded from address alone
   always_comb begin
      readdata = '0;
      if (is_data_addr(address)) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (address[2:0] == 3'(i)) readdata = 32'(data_q[i]);
         end
      end else begin
         case (address)
            ADDR_BLINK_MASK:   readdata = 32'(mask_q);
            ADDR_BLINK_PERIOD: readdata = 32'(period_q);
            ADDR_CTRL:         readdata = 32'(ctrl_q);
            ADDR_STATUS:       readdata[STATUS_PHASE_BIT] = phase;
            default:           readdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_arm_hps_system_hex_bank.sv
// Randomized self-checking bench for arm_hps_system_hex_bank against an elapsed-time model.
module tb_arm_hps_system_hex_bank;

   localparam int unsigned NUM_CH = 6;
   localparam int unsigned CH_W   = 8;
   localparam int unsigned DIV_W  = 26;
   localparam int unsigned OUT_W  = NUM_CH * CH_W;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [3:0]       address;
   logic             chipselect;
   logic             write_n;
   logic [31:0]      writedata;
   logic [31:0]      readdata;
   logic [OUT_W-1:0] out_port;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: phase is derived from edges elapsed since the period was set
   logic [CH_W-1:0]   m_data [8];
   logic [NUM_CH-1:0] m_mask;
   logic [DIV_W-1:0]  m_period;
   logic              m_en;
   logic              m_inv;
   int                m_elapsed;

   arm_hps_system_hex_bank #(
      .NUM_CH(NUM_CH), .CH_W(CH_W), .DIV_W(DIV_W), .INV_RST(1'b0)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic m_phase();
      if (m_period == '0) return 1'b0;
      return ((m_elapsed / int'(m_period)) % 2) == 1;
   endfunction

   function automatic logic [OUT_W-1:0] m_out();
      logic [OUT_W-1:0] o;
      o = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         logic [CH_W-1:0] v;
         v = (m_en && !(m_mask[i] && m_phase())) ? m_data[i] : '0;
         o[i*CH_W +: CH_W] = v ^ {CH_W{m_inv}};
      end
      return o;
   endfunction

   function automatic logic [31:0] m_read(input logic [3:0] a);
      if (a < 4'd8) return (int'(a) < NUM_CH) ? 32'(m_data[a[2:0]]) : 32'd0;
      case (a)
         4'h8:    return 32'(m_mask);
         4'h9:    return 32'(m_period);
         4'hA:    return {30'd0, m_inv, m_en};
         4'hB:    return {31'd0, m_phase()};
         default: return 32'd0;
      endcase
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 8; i++) m_data[i] = '0;
      m_mask = '0; m_period = '0; m_en = 1'b1; m_inv = 1'b0; m_elapsed = 0;
   endtask

   // One bus cycle: drive, clock, advance model, check registered output
   task automatic step(input logic cs, input logic wn, input logic [3:0] a, input logic [31:0] wd);
      logic [OUT_W-1:0] exp_out;
      logic wr;
      chipselect = cs; write_n = wn; address = a; writedata = wd;
      @(posedge clk);
      exp_out = m_out();
      wr = cs && !wn;
      if (wr && a == 4'h9) m_elapsed = 0;
      else if (m_period != '0) m_elapsed++;
      if (wr) begin
         if (a < 4'd8) begin
            if (int'(a) < NUM_CH) m_data[a[2:0]] = wd[CH_W-1:0];
         end else begin
            case (a)
               4'h8: m_mask = wd[NUM_CH-1:0];
               4'h9: m_period = wd[DIV_W-1:0];
               4'hA: begin m_en = wd[0]; m_inv = wd[1]; end
               4'hC: m_mask = m_mask | wd[NUM_CH-1:0];
               4'hD: m_mask = m_mask & ~wd[NUM_CH-1:0];
               default: ;
            endcase
         end
      end
      #1;
      check("out_port", 64'(out_port), 64'(exp_out));
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd_chk(input logic [3:0] a);
      address = a;
      #1;
      check($sformatf("rd_%h", a), 64'(readdata), 64'(m_read(a)));
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         step(1'b0, 1'b1, 4'h0, 32'd0);
         rd_chk(4'hB);
      end
   endtask

   initial begin
      logic [3:0]  a;
      logic [31:0] wd;
      logic        cs, wn;

      reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_out", 64'(out_port), 64'd0);
      rd_chk(4'hA);
      rd_chk(4'h9);
      @(negedge clk);
      reset_n = 1'b1;

      // Single data write, one-cycle output latency
      step(1'b1, 1'b0, 4'h2, 32'h0000_005A);
      check("d2_lat0", 64'(out_port), 64'd0);
      step(1'b0, 1'b1, 4'h0, 32'd0);
      check("d2_out", 64'(out_port), 64'h0000_005A_0000);
      rd_chk(4'h2);

      // Blink channel 2 with a 4-cycle half-period
      step(1'b1, 1'b0, 4'h9, 32'd4);
      step(1'b1, 1'b0, 4'hC, 32'h04);
      rd_chk(4'h8);
      idle(14);

      // Restart the period while PHASE is high
      for (int k = 0; k < 8 && !m_phase(); k++) idle(1);
      check("phase_hi", 64'(m_phase()), 64'd1);
      step(1'b1, 1'b0, 4'h9, 32'd4);
      rd_chk(4'hB);
      idle(10);

      // Enable/invert combinations on a steady display
      step(1'b1, 1'b0, 4'hD, 32'h04);
      step(1'b1, 1'b0, 4'hA, 32'h2);
      step(1'b0, 1'b1, 4'h0, 32'd0);
      check("blank_inv", 64'(out_port), 64'hFFFF_FFFF_FFFF);
      step(1'b1, 1'b0, 4'hA, 32'h3);
      step(1'b0, 1'b1, 4'h0, 32'd0);
      check("inv_on", 64'(out_port), 64'hFFFF_FFA5_FFFF);
      rd_chk(4'hA);
      step(1'b1, 1'b0, 4'hA, 32'h1);

      // Out-of-range, unmapped, read-only and unselected writes
      step(1'b1, 1'b0, 4'h7, 32'hFF);
      step(1'b1, 1'b0, 4'hE, 32'hFFFF_FFFF);
      step(1'b1, 1'b0, 4'hB, 32'hFFFF_FFFF);
      step(1'b0, 1'b0, 4'h0, 32'hFF);
      step(1'b0, 1'b1, 4'h0, 32'd0);
      check("no_change", 64'(out_port), 64'h0000_005A_0000);
      rd_chk(4'h7);
      rd_chk(4'hE);
      rd_chk(4'hC);

      // Asynchronous reset in the middle of blinking
      step(1'b1, 1'b0, 4'h9, 32'd3);
      step(1'b1, 1'b0, 4'hC, 32'h3F);
      idle(5);
      reset_n = 1'b0;
      #1;
      m_reset();
      check("async_rst", 64'(out_port), 64'd0);
      rd_chk(4'h9);
      rd_chk(4'hA);
      reset_n = 1'b1;
      idle(3);

      // Random traffic
      for (int it = 0; it < 600; it++) begin
         a  = 4'($urandom_range(0, 15));
         cs = ($urandom_range(0, 7) != 0);
         wn = ($urandom_range(0, 2) == 0);
         wd = $urandom;
         if (a == 4'h9) wd = 32'($urandom_range(0, 7)) | (32'($urandom_range(0, 1)) << 28);
         if (a == 4'hA && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
         step(cs, wn, a, wd);
         rd_chk(4'($urandom_range(0, 15)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
